f_pc_control: RTL and testbench

Fetch-stage program-counter sequencer for the five-stage MIPS pipeline. It consumes the jump/branch codes that the decode stage produces (`jump`, `bop`) together with decode operands, and resolves branches and jumps without a delay slot. It runs the instruction-memory request/acknowledge handshake and owns the IF/ID instruction register, including a one-entry skid buffer. On a redirect it flushes wrong-path fetches and pulses a flush to decode.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/f_pc_control_if.sv | 28 ++
 rtl/pc_target_calc.sv | 51 +++++
 rtl/f_pc_control.sv | 193 +++++++++++++++++++
 tb/tb_f_pc_control.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared encodings for the five-stage MIPS pipeline front end.
//   - jump codes produced by decode (JMP_*)
//   - branch-operation codes produced by decode (BOP_*)
//   - fetch sequencer state type
//   - branch target helper (word offset, sign-extended, 32-bit wrap)
package pipe_pkg;

  localparam logic [1:0] JMP_NONE = 2'b00;  // branch or no control transfer
  localparam logic [1:0] JMP_J    = 2'b01;  // j / jal
  localparam logic [1:0] JMP_JR   = 2'b10;  // jr
  localparam logic [1:0] JMP_SEQ  = 2'b11;  // ordinary non-control instruction

  localparam logic [1:0] BOP_NONE = 2'b00;
  localparam logic [1:0] BOP_BNE  = 2'b10;
  localparam logic [1:0] BOP_BEQ  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_DRAIN = 2'b10
  } fetch_state_t;

  // Branch target: PC+4 plus the word offset scaled to bytes; wraps modulo 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                input logic [15:0] imm);
    return pc4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/f_pc_control_if.sv
// f_pc_control_if: instruction-memory request/acknowledge bus.
//   o_imem_req   fetch request (fetch -> memory)
//   o_imem_addr  fetch address (fetch -> memory)
//   i_imem_ack   request complete, read data valid (memory -> fetch)
//   i_imem_rdata instruction word (memory -> fetch)
// Signal names are written from the fetch unit's point of view.
interface f_pc_control_if;

  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;

  modport master (
    output o_imem_req,
    output o_imem_addr,
    input  i_imem_ack,
    input  i_imem_rdata
  );

  modport slave (
    input  o_imem_req,
    input  o_imem_addr,
    output i_imem_ack,
    output i_imem_rdata
  );

endinterface

// File: rtl/pc_target_calc.sv
// pc_target_calc: combinational redirect decision and target for the
// instruction currently in decode.
//   i_jump/i_bop  decode control codes
//   i_eq          rs == rt
//   i_pc4         PC+4 of the decode instruction
//   i_imm/i_jidx  branch offset (words) / jump index
//   i_rs          jr target
//   o_taken       control transfer is taken (before dvalid/stall qualification)
//   o_target      redirect address
module pc_target_calc
  import pipe_pkg::*;
(
  input  logic [1:0]  i_jump,
  input  logic [1:0]  i_bop,
  input  logic        i_eq,
  input  logic [31:0] i_pc4,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_jidx,
  input  logic [31:0] i_rs,
  output logic        o_taken,
  output logic [31:0] o_target
);

  // Taken decision and target selection by jump class.
  always_comb begin
    o_taken  = 1'b0;
    o_target = i_pc4;
    case (i_jump)
      JMP_J: begin
        o_taken  = 1'b1;
        o_target = {i_pc4[31:28], i_jidx, 2'b00};
      end
      JMP_JR: begin
        o_taken  = 1'b1;
        o_target = i_rs;
      end
      JMP_NONE: begin
        o_target = branch_target(i_pc4, i_imm);
        case (i_bop)
          BOP_BEQ:  o_taken = i_eq;
          BOP_BNE:  o_taken = ~i_eq;
          BOP_NONE: o_taken = 1'b0;
          default:  o_taken = 1'b0;
        endcase
      end
      JMP_SEQ: o_taken = 1'b0;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/f_pc_control.sv
// f_pc_control: fetch-stage PC sequencer. Issues instruction fetches over
// the imem bus, owns the IF/ID register plus a one-entry skid buffer, and
// resolves jumps/branches from decode with no delay slot.
//   i_clk, i_rst_n      clock, async active-low reset
//   i_con_*             decode control/operands (jump, bop, dvalid, stall,
//                       eq, pc4, imm, jidx, rs)
//   imem                instruction memory bus (master side)
//   o_if_valid/instru/pc4  IF/ID register contents
//   o_con_flush         one-cycle pulse after a redirect
module f_pc_control
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [1:0]     i_con_jump,
  input  logic [1:0]     i_con_bop,
  input  logic           i_con_dvalid,
  input  logic           i_con_stall,
  input  logic           i_con_eq,
  input  logic [31:0]    i_con_pc4,
  input  logic [15:0]    i_con_imm,
  input  logic [25:0]    i_con_jidx,
  input  logic [31:0]    i_con_rs,
  f_pc_control_if.master imem,
  output logic           o_if_valid,
  output logic [31:0]    o_if_instru,
  output logic [31:0]    o_if_pc4,
  output logic           o_con_flush
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drain_addr_q, drain_addr_d;
  logic         skid_valid_q, skid_valid_d;
  logic [31:0]  skid_instr_q, skid_instr_d;
  logic [31:0]  skid_pc4_q, skid_pc4_d;
  logic         if_valid_q, if_valid_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic [31:0]  if_pc4_q, if_pc4_d;
  logic         flush_q, flush_d;

  logic         taken;
  logic [31:0]  target;
  logic         redirect;
  logic         req;
  logic         ack_fetch;

  pc_target_calc u_target (
    .i_jump   (i_con_jump),
    .i_bop    (i_con_bop),
    .i_eq     (i_con_eq),
    .i_pc4    (i_con_pc4),
    .i_imm    (i_con_imm),
    .i_jidx   (i_con_jidx),
    .i_rs     (i_con_rs),
    .o_taken  (taken),
    .o_target (target)
  );

  // Request is a function of registered state only; a full skid throttles fetch.
  assign req = ((state_q == S_FETCH) && !skid_valid_q) || (state_q == S_DRAIN);
  assign imem.o_imem_req  = req;
  // While draining, the bus keeps the abandoned address; pc_q already holds the target.
  assign imem.o_imem_addr = (state_q == S_DRAIN) ? drain_addr_q : pc_q;

  // A stalled decode cannot redirect; it will re-present the instruction.
  assign redirect  = i_con_dvalid & ~i_con_stall & taken;
  assign ack_fetch = (state_q == S_FETCH) & req & imem.i_imem_ack;

  // Next-state logic for the sequencer, PC, skid buffer and IF/ID register.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc4_d     = if_pc4_q;
    flush_d      = redirect;

    // IF/ID and skid: a redirect wipes both and drops any returning data.
    if (redirect) begin
      if_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
    end else if (if_valid_q && !i_con_stall) begin
      if (skid_valid_q) begin
        if_instr_d   = skid_instr_q;
        if_pc4_d     = skid_pc4_q;
        skid_valid_d = 1'b0;
      end else if (ack_fetch) begin
        if_instr_d = imem.i_imem_rdata;
        if_pc4_d   = pc_q + 32'd4;
      end else begin
        if_valid_d = 1'b0;
      end
    end else if (if_valid_q) begin
      if (ack_fetch) begin
        skid_valid_d = 1'b1;
        skid_instr_d = imem.i_imem_rdata;
        skid_pc4_d   = pc_q + 32'd4;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end else begin
      if (ack_fetch) begin
        if_valid_d = 1'b1;
        if_instr_d = imem.i_imem_rdata;
        if_pc4_d   = pc_q + 32'd4;
      end else begin
        if_valid_d = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        if (redirect) begin
          pc_d = target;
        end else begin
          pc_d = pc_q;
        end
      end
      S_FETCH: begin
        if (redirect) begin
          pc_d = target;
          // An un-acked request must be carried to completion before refetching.
          if (req && !imem.i_imem_ack) begin
            state_d      = S_DRAIN;
            drain_addr_d = pc_q;
          end else begin
            state_d = S_FETCH;
          end
        end else if (ack_fetch) begin
          pc_d = pc_q + 32'd4;
        end else begin
          pc_d = pc_q;
        end
      end
      S_DRAIN: begin
        if (redirect) begin
          pc_d = target;
        end else begin
          pc_d = pc_q;
        end
        if (imem.i_imem_ack) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with asynchronous reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      skid_valid_q <= 1'b0;
      skid_instr_q <= 32'd0;
      skid_pc4_q   <= 32'd0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= 32'd0;
      if_pc4_q     <= 32'd0;
      flush_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc4_q     <= if_pc4_d;
      flush_q      <= flush_d;
    end
  end

  assign o_if_valid  = if_valid_q;
  assign o_if_instru = if_instr_q;
  assign o_if_pc4    = if_pc4_q;
  assign o_con_flush = flush_q;

endmodule

// File: tb/tb_f_pc_control.sv
// tb_f_pc_control: directed and randomized checks of f_pc_control against a
// behavioural model. The model treats IF/ID plus skid as a two-deep FIFO of
// fetched {instruction, pc4} pairs whose head is IF/ID, plus a PC and a
// "draining" flag holding the abandoned fetch address.
module tb_f_pc_control;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [1:0]  i_con_jump;
  logic [1:0]  i_con_bop;
  logic        i_con_dvalid;
  logic        i_con_stall;
  logic        i_con_eq;
  logic [31:0] i_con_pc4;
  logic [15:0] i_con_imm;
  logic [25:0] i_con_jidx;
  logic [31:0] i_con_rs;
  logic        o_if_valid;
  logic [31:0] o_if_instru;
  logic [31:0] o_if_pc4;
  logic        o_con_flush;
  logic        ack_en;

  int checks = 0;
  int errors = 0;

  f_pc_control_if imem_bus ();

  f_pc_control #(.RESET_PC(RST_PC)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_con_jump   (i_con_jump),
    .i_con_bop    (i_con_bop),
    .i_con_dvalid (i_con_dvalid),
    .i_con_stall  (i_con_stall),
    .i_con_eq     (i_con_eq),
    .i_con_pc4    (i_con_pc4),
    .i_con_imm    (i_con_imm),
    .i_con_jidx   (i_con_jidx),
    .i_con_rs     (i_con_rs),
    .imem         (imem_bus),
    .o_if_valid   (o_if_valid),
    .o_if_instru  (o_if_instru),
    .o_if_pc4     (o_if_pc4),
    .o_con_flush  (o_con_flush)
  );

  always #5 i_clk = ~i_clk;

  // Model state
  bit          m_idle;
  bit          m_drain;
  bit          m_flush;
  logic [31:0] m_pc;
  logic [31:0] m_daddr;
  logic [63:0] m_q[$];   // {instr, pc4}; element 0 is IF/ID, element 1 is skid

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h1357_9BDF;
  endfunction

  function automatic bit exp_req();
    return !m_idle && (m_drain || (m_q.size() < 2));
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idle  = 1'b1;
    m_drain = 1'b0;
    m_flush = 1'b0;
    m_pc    = RST_PC;
    m_daddr = RST_PC;
    m_q.delete();
  endtask

  task automatic check_outputs();
    chk1("req", imem_bus.o_imem_req, exp_req());
    chk32("addr", imem_bus.o_imem_addr, m_drain ? m_daddr : m_pc);
    chk1("if_valid", o_if_valid, m_q.size() > 0);
    chk1("flush", o_con_flush, m_flush);
    if (m_q.size() > 0) begin
      chk32("if_instru", o_if_instru, m_q[0][63:32]);
      chk32("if_pc4", o_if_pc4, m_q[0][31:0]);
    end
  endtask

  // Advance the model by one clock given the inputs applied this cycle.
  task automatic model_step(input bit ack_in);
    bit          req0;
    bit          ackv;
    bit          tk;
    bit          redir;
    logic [31:0] tgt;
    int          off;
    req0 = exp_req();
    ackv = req0 && ack_in;
    tk   = 1'b0;
    tgt  = 32'd0;
    if (i_con_jump == 2'd1) begin
      tk  = 1'b1;
      tgt = (i_con_pc4 & 32'hF000_0000) | (32'(i_con_jidx) << 2);
    end else if (i_con_jump == 2'd2) begin
      tk  = 1'b1;
      tgt = i_con_rs;
    end else if (i_con_jump == 2'd0) begin
      off = $signed(i_con_imm);
      tgt = i_con_pc4 + 32'(off * 4);
      tk  = ((i_con_bop == 2'd3) && i_con_eq) || ((i_con_bop == 2'd2) && !i_con_eq);
    end
    redir = i_con_dvalid && !i_con_stall && tk;

    if (m_idle) begin
      m_idle = 1'b0;
      if (redir) begin
        m_pc = tgt;
        m_q.delete();
      end
    end else if (m_drain) begin
      if (redir) begin
        m_pc = tgt;
        m_q.delete();
      end else if (m_q.size() > 0 && !i_con_stall) begin
        void'(m_q.pop_front());
      end
      if (ackv) m_drain = 1'b0;
    end else begin
      if (redir) begin
        if (req0 && !ackv) begin
          m_drain = 1'b1;
          m_daddr = m_pc;
        end
        m_pc = tgt;
        m_q.delete();
      end else begin
        if (m_q.size() > 0 && !i_con_stall) void'(m_q.pop_front());
        if (ackv) begin
          m_q.push_back({mem_word(m_pc), m_pc + 32'd4});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    m_flush = redir;
  endtask

  // One cycle: check at negedge, answer the bus, step the model, move to next negedge.
  task automatic tick();
    bit a;
    check_outputs();
    a = ack_en;
    imem_bus.i_imem_ack   = a & imem_bus.o_imem_req;
    imem_bus.i_imem_rdata = mem_word(imem_bus.o_imem_addr);
    model_step(a);
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic dec_idle();
    i_con_dvalid = 1'b0;
    i_con_stall  = 1'b0;
    i_con_jump   = 2'b11;
    i_con_bop    = 2'b00;
    i_con_eq     = 1'b0;
    i_con_pc4    = 32'd0;
    i_con_imm    = 16'd0;
    i_con_jidx   = 26'd0;
    i_con_rs     = 32'd0;
  endtask

  task automatic dec_set(input logic [1:0] j, input logic [1:0] b, input logic e,
                         input logic [31:0] p4, input logic [15:0] im,
                         input logic [25:0] ji, input logic [31:0] r);
    i_con_dvalid = 1'b1;
    i_con_stall  = 1'b0;
    i_con_jump   = j;
    i_con_bop    = b;
    i_con_eq     = e;
    i_con_pc4    = p4;
    i_con_imm    = im;
    i_con_jidx   = ji;
    i_con_rs     = r;
  endtask

  initial begin
    logic [31:0] held_instr;
    logic [31:0] held_pc4;
    logic [31:0] r;
    dec_idle();
    ack_en = 1'b0;
    imem_bus.i_imem_ack   = 1'b0;
    imem_bus.i_imem_rdata = 32'd0;
    model_reset();
    repeat (3) @(negedge i_clk);

    // Reset values
    chk1("rst_req", imem_bus.o_imem_req, 1'b0);
    chk32("rst_addr", imem_bus.o_imem_addr, RST_PC);
    chk1("rst_if_valid", o_if_valid, 1'b0);
    chk32("rst_if_instru", o_if_instru, 32'd0);
    chk32("rst_if_pc4", o_if_pc4, 32'd0);
    chk1("rst_flush", o_con_flush, 1'b0);
    i_rst_n = 1'b1;

    // Sequential zero-wait fetch
    ack_en = 1'b1;
    tick(); chk1("seq_req", imem_bus.o_imem_req, 1'b1); chk32("seq_addr0", imem_bus.o_imem_addr, 32'h0);
    tick(); chk32("seq_addr1", imem_bus.o_imem_addr, 32'h4); chk32("seq_pc4_a", o_if_pc4, 32'h4);
    tick(); chk32("seq_addr2", imem_bus.o_imem_addr, 32'h8); chk32("seq_pc4_b", o_if_pc4, 32'h8);
    tick(); chk32("seq_pc4_c", o_if_pc4, 32'hC);

    // beq taken: 0x14 + (-2 * 4) = 0x0C
    dec_set(2'b00, 2'b11, 1'b1, 32'h14, 16'hFFFE, 26'd0, 32'd0);
    tick();
    chk1("beq_flush", o_con_flush, 1'b1);
    chk1("beq_if_inval", o_if_valid, 1'b0);
    chk32("beq_addr", imem_bus.o_imem_addr, 32'h0000_000C);
    dec_idle();
    tick();
    chk1("beq_flush_off", o_con_flush, 1'b0);
    chk32("beq_tgt_pc4", o_if_pc4, 32'h10);
    chk32("beq_tgt_instr", o_if_instru, mem_word(32'hC));

    // beq not taken
    dec_set(2'b00, 2'b11, 1'b0, 32'h14, 16'hFFFE, 26'd0, 32'd0);
    tick();
    chk1("beq_nt_flush", o_con_flush, 1'b0);
    chk1("beq_nt_valid", o_if_valid, 1'b1);
    dec_idle();
    tick();

    // jal and jr
    dec_set(2'b01, 2'b00, 1'b0, 32'h1000_0008, 16'd0, 26'h0000040, 32'd0);
    tick();
    chk32("jal_addr", imem_bus.o_imem_addr, 32'h1000_0100);
    chk1("jal_flush", o_con_flush, 1'b1);
    dec_idle();
    tick();
    dec_set(2'b10, 2'b00, 1'b0, 32'd0, 16'd0, 26'd0, 32'h0000_0200);
    tick();
    chk32("jr_addr", imem_bus.o_imem_addr, 32'h0000_0200);
    dec_idle();
    tick();
    tick();

    // Stall three cycles with IF/ID valid: skid fills, req drops, IF/ID holds
    chk1("stall_pre_valid", o_if_valid, 1'b1);
    held_instr = o_if_instru;
    held_pc4   = o_if_pc4;
    dec_set(2'b11, 2'b00, 1'b0, 32'd0, 16'd0, 26'd0, 32'd0);
    i_con_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1("stall_req", imem_bus.o_imem_req, 1'b0);
      chk32("stall_instr", o_if_instru, held_instr);
    end
    dec_idle();
    tick();
    chk32("unstall_pc4", o_if_pc4, held_pc4 + 32'd4);
    chk1("unstall_req", imem_bus.o_imem_req, 1'b1);
    tick();

    // Redirect with outstanding req at 0x20, ack delayed
    dec_set(2'b10, 2'b00, 1'b0, 32'd0, 16'd0, 26'd0, 32'h0000_0020);
    tick();
    chk32("drain_setup_addr", imem_bus.o_imem_addr, 32'h20);
    ack_en = 1'b0;
    dec_set(2'b10, 2'b00, 1'b0, 32'd0, 16'd0, 26'd0, 32'h0000_0300);
    tick();
    chk1("drain_flush", o_con_flush, 1'b1);
    chk1("drain_req", imem_bus.o_imem_req, 1'b1);
    chk32("drain_addr0", imem_bus.o_imem_addr, 32'h20);
    dec_idle();
    tick(); chk32("drain_addr1", imem_bus.o_imem_addr, 32'h20);
    tick(); chk32("drain_addr2", imem_bus.o_imem_addr, 32'h20);
    ack_en = 1'b1;
    tick();
    chk32("drain_done_addr", imem_bus.o_imem_addr, 32'h300);
    chk1("drain_discard", o_if_valid, 1'b0);
    tick();
    chk32("drain_tgt_pc4", o_if_pc4, 32'h304);
    tick();
    tick();

    // Asynchronous reset in the middle of a request
    #2;
    i_rst_n = 1'b0;
    #1;
    chk1("arst_req", imem_bus.o_imem_req, 1'b0);
    chk32("arst_addr", imem_bus.o_imem_addr, RST_PC);
    chk1("arst_if_valid", o_if_valid, 1'b0);
    chk32("arst_if_instru", o_if_instru, 32'd0);
    chk32("arst_if_pc4", o_if_pc4, 32'd0);
    chk1("arst_flush", o_con_flush, 1'b0);
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    chk32("arst_first_addr", imem_bus.o_imem_addr, RST_PC);
    chk1("arst_first_req", imem_bus.o_imem_req, 1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      i_con_dvalid = ($urandom_range(0, 9) < 4);
      i_con_stall  = ($urandom_range(0, 3) == 0);
      i_con_jump   = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: i_con_bop = 2'b00;
        1: i_con_bop = 2'b10;
        default: i_con_bop = 2'b11;
      endcase
      i_con_eq   = 1'($urandom_range(0, 1));
      r          = $urandom();
      i_con_pc4  = r & 32'hFFFF_FFFC;
      i_con_imm  = 16'($urandom());
      i_con_jidx = 26'($urandom());
      r          = $urandom();
      i_con_rs   = r & 32'hFFFF_FFFC;
      ack_en     = ($urandom_range(0, 9) < 7);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
